// File: rtl/shotclock_ctrl_pkg.sv
// Shared types and constants for the shot-clock controller.
package shotclock_ctrl_pkg;

    localparam int unsigned DIGIT_W = 4;

    // Display code for a blanked digit
    localparam logic [DIGIT_W-1:0] BLANK = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

endpackage

// File: rtl/shotclock_ctrl_tick_gen.sv
// Prescaler: counts 0..DIV-1 while en, emits a one-cycle tick on the last count.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   clr        restart the count at 0 (overrides en, suppresses tick)
//   en         advance the count
//   tick_c     combinational tick, high when the count wraps this cycle
module shotclock_ctrl_tick_gen #(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick_c
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'((DIV > 0) ? DIV - 1 : 0);

    logic [CW-1:0] cnt;

    // Wrapping divider count
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign tick_c = en && !clr && (cnt == LAST);

endmodule

// File: rtl/shotclock_ctrl.sv
// Shot-clock controller: BCD countdown in tenths of a second with pause/resume,
// full and short reloads, "s.t" display near expiry, expiry state and timed buzzer.
// Ports:
//   clk, rst                           clock, synchronous active-high reset
//   load_full, load_short, start_stop  one-cycle button pulses
//   digits_o  [4*DIGITS-1:0]           BCD digits, [3:0] rightmost, 4'hF blank
//   dp_n_o    [DIGITS-1:0]             decimal points, active-low
//   running_o, expired_o, buzzer_o     registered status flags
module shotclock_ctrl
    import shotclock_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned DIGITS       = 2,
    parameter int unsigned FULL_VALUE   = 24,
    parameter int unsigned SHORT_VALUE  = 14,
    parameter int unsigned TENTHS_BELOW = 5,
    parameter int unsigned BUZZ_MS      = 1000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load_full,
    input  logic                        load_short,
    input  logic                        start_stop,
    output logic [DIGIT_W*DIGITS-1:0]   digits_o,
    output logic [DIGITS-1:0]           dp_n_o,
    output logic                        running_o,
    output logic                        expired_o,
    output logic                        buzzer_o
);

    localparam int unsigned SEC_W    = DIGIT_W * DIGITS;
    localparam int unsigned TICK_DIV = (CLK_HZ >= 10) ? CLK_HZ / 10 : 1;
    localparam int unsigned MS_DIV   = (CLK_HZ >= 1000) ? CLK_HZ / 1000 : 1;
    localparam int unsigned MS_W     = (BUZZ_MS > 1) ? $clog2(BUZZ_MS) : 1;
    localparam int unsigned MS_LAST  = (BUZZ_MS > 0) ? BUZZ_MS - 1 : 0;

    // Binary constant to packed BCD
    function automatic logic [SEC_W-1:0] to_bcd(input int unsigned v);
        logic [SEC_W-1:0] r;
        int unsigned      x;
        r = '0;
        x = v;
        for (int i = 0; i < int'(DIGITS); i++) begin
            r[i*DIGIT_W +: DIGIT_W] = DIGIT_W'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Packed BCD compares numerically as a plain unsigned vector
    localparam logic [SEC_W-1:0] FULL_BCD   = to_bcd(FULL_VALUE);
    localparam logic [SEC_W-1:0] SHORT_BCD  = to_bcd(SHORT_VALUE);
    localparam logic [SEC_W-1:0] TENTHS_BCD = to_bcd(TENTHS_BELOW);

    // Remaining time minus 0.1 s, with multi-digit BCD borrow into seconds
    function automatic logic [SEC_W+DIGIT_W-1:0] dec_time(
        input logic [SEC_W-1:0]   s,
        input logic [DIGIT_W-1:0] t
    );
        logic [SEC_W-1:0]   ns;
        logic [DIGIT_W-1:0] nt;
        logic               borrow;
        ns     = s;
        nt     = t - DIGIT_W'(1);
        borrow = (t == '0);
        if (borrow) begin
            nt = DIGIT_W'(9);
        end
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (borrow) begin
                if (ns[i*DIGIT_W +: DIGIT_W] == '0) begin
                    ns[i*DIGIT_W +: DIGIT_W] = DIGIT_W'(9);
                end else begin
                    ns[i*DIGIT_W +: DIGIT_W] = ns[i*DIGIT_W +: DIGIT_W] - DIGIT_W'(1);
                    borrow = 1'b0;
                end
            end
        end
        return {ns, nt};
    endfunction

    // Digit formatter: zeros when expired, "s.t" near expiry, else blanked seconds
    function automatic logic [SEC_W-1:0] fmt_digits(
        input state_t             st,
        input logic [SEC_W-1:0]   s,
        input logic [DIGIT_W-1:0] t
    );
        logic [SEC_W-1:0] d;
        logic             lead;
        d    = s;
        lead = 1'b1;
        if (st == ST_EXPIRED) begin
            d = '0;
        end else if (s < TENTHS_BCD) begin
            d = {DIGITS{BLANK}};
            d[DIGIT_W +: DIGIT_W] = s[0 +: DIGIT_W];
            d[0 +: DIGIT_W]       = t;
        end else begin
            for (int i = int'(DIGITS) - 1; i > 0; i--) begin
                if (lead && (s[i*DIGIT_W +: DIGIT_W] == '0)) begin
                    d[i*DIGIT_W +: DIGIT_W] = BLANK;
                end else begin
                    lead = 1'b0;
                end
            end
        end
        return d;
    endfunction

    // Decimal point after the units digit only in "s.t" mode
    function automatic logic [DIGITS-1:0] fmt_dp(
        input state_t           st,
        input logic [SEC_W-1:0] s
    );
        logic [DIGITS-1:0] d;
        d = '1;
        if ((st != ST_EXPIRED) && (s < TENTHS_BCD)) begin
            d[1] = 1'b0;
        end
        return d;
    endfunction

    state_t                   state, state_nxt;
    logic [SEC_W-1:0]         secs, secs_nxt;
    logic [DIGIT_W-1:0]       tenths, tenths_nxt;
    logic [SEC_W+DIGIT_W-1:0] dec_c;
    logic                     load_c, run_c, presc_clr_c, tick_c;
    logic                     buzz_start_c, ms_clr_c, ms_tick_c;
    logic                     buzz_on;
    logic [MS_W-1:0]          ms_cnt;

    assign load_c       = load_full || load_short;
    assign run_c        = (state == ST_RUN);
    assign dec_c        = dec_time(secs, tenths);
    assign buzz_start_c = (state_nxt == ST_EXPIRED) && (state != ST_EXPIRED);
    assign ms_clr_c     = buzz_start_c || load_c;

    // 0.1 s tick, only while running
    shotclock_ctrl_tick_gen #(.DIV(TICK_DIV)) u_tenths_tick (
        .clk    (clk),
        .rst    (rst),
        .clr    (presc_clr_c),
        .en     (run_c),
        .tick_c (tick_c)
    );

    // 1 ms tick for the buzzer timer
    shotclock_ctrl_tick_gen #(.DIV(MS_DIV)) u_ms_tick (
        .clk    (clk),
        .rst    (rst),
        .clr    (ms_clr_c),
        .en     (buzz_on),
        .tick_c (ms_tick_c)
    );

    // State and remaining-time registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            secs   <= FULL_BCD;
            tenths <= '0;
        end else begin
            state  <= state_nxt;
            secs   <= secs_nxt;
            tenths <= tenths_nxt;
        end
    end

    // Next state: load_full > load_short > start_stop > tick
    always_comb begin
        state_nxt   = state;
        secs_nxt    = secs;
        tenths_nxt  = tenths;
        presc_clr_c = 1'b0;
        if (load_c) begin
            presc_clr_c = 1'b1;
            if (load_full) begin
                secs_nxt   = FULL_BCD;
                tenths_nxt = '0;
            end else if (secs < SHORT_BCD) begin
                secs_nxt   = SHORT_BCD;
                tenths_nxt = '0;
            end
            if (state == ST_EXPIRED) begin
                state_nxt = ST_IDLE;
            end
        end else if (start_stop) begin
            case (state)
                ST_IDLE, ST_PAUSE: begin
                    state_nxt   = ST_RUN;
                    presc_clr_c = 1'b1;
                end
                ST_RUN:  state_nxt = ST_PAUSE;
                default: state_nxt = state;
            endcase
        end else if (tick_c) begin
            {secs_nxt, tenths_nxt} = dec_c;
            if (dec_c == '0) begin
                state_nxt = ST_EXPIRED;
            end
        end
    end

    // Buzzer: BUZZ_MS ms-ticks from entry into EXPIRED; any load silences it
    always_ff @(posedge clk) begin
        if (rst || load_c) begin
            buzz_on <= 1'b0;
            ms_cnt  <= '0;
        end else if (buzz_start_c) begin
            buzz_on <= 1'b1;
            ms_cnt  <= '0;
        end else if (buzz_on && ms_tick_c) begin
            if (ms_cnt == MS_W'(MS_LAST)) begin
                buzz_on <= 1'b0;
            end else begin
                ms_cnt <= ms_cnt + MS_W'(1);
            end
        end
    end

    // Output registers, one cycle behind state/count
    always_ff @(posedge clk) begin
        if (rst) begin
            digits_o  <= fmt_digits(ST_IDLE, FULL_BCD, '0);
            dp_n_o    <= fmt_dp(ST_IDLE, FULL_BCD);
            running_o <= 1'b0;
            expired_o <= 1'b0;
            buzzer_o  <= 1'b0;
        end else begin
            digits_o  <= fmt_digits(state, secs, tenths);
            dp_n_o    <= fmt_dp(state, secs);
            running_o <= (state == ST_RUN);
            expired_o <= (state == ST_EXPIRED);
            buzzer_o  <= buzz_on;
        end
    end

endmodule
